// File: rtl/syscall_sequencer_pkg.sv
// Shared constants and state encoding for the SYSCALL sequencer.
// Holds the syscall codes, the ASCII anchors and the FSM state type.
package syscall_sequencer_pkg;

   localparam int unsigned DefaultMaxLen = 256;

   localparam logic [31:0] SysPrintStr  = 32'd4;
   localparam logic [31:0] SysPrintHex  = 32'd1;
   localparam logic [31:0] SysPrintChar = 32'd11;
   localparam logic [31:0] SysExit      = 32'd10;

   localparam logic [7:0] AsciiZero   = 8'h30;
   localparam logic [7:0] AsciiUpperA = 8'h41;

   typedef enum logic [2:0] {
      StIdle,
      StStrReq,
      StStrWait,
      StStrEmit,
      StHexEmit,
      StChrEmit,
      StFinish
   } state_e;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Maps a 4-bit value to its upper-case ASCII hex digit.
module hex_nibble_to_ascii
   import syscall_sequencer_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   always_comb begin
      if (nibble < 4'd10) begin
         ascii = AsciiZero + {4'd0, nibble};
      end else begin
         ascii = AsciiUpperA + {4'd0, nibble} - 8'd10;
      end
   end

endmodule

// File: rtl/syscall_sequencer.sv
// Multi-cycle SYSCALL service FSM: stalls the pipeline, reads strings from data memory
// and streams characters to a valid/ready console sink; raises a sticky halt on exit.
module syscall_sequencer
   import syscall_sequencer_pkg::*;
#(
   parameter int unsigned MAX_LEN        = DefaultMaxLen,
   parameter logic [31:0] SYS_PRINT_STR  = SysPrintStr,
   parameter logic [31:0] SYS_PRINT_HEX  = SysPrintHex,
   parameter logic [31:0] SYS_PRINT_CHAR = SysPrintChar,
   parameter logic [31:0] SYS_EXIT       = SysExit
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        syscall,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [7:0]  char_out,
   output logic        char_valid,
   input  logic        char_ready,
   output logic        stall,
   output logic        done,
   output logic        halt
);

   localparam int unsigned LenW = $clog2(MAX_LEN + 1);
   localparam logic [LenW-1:0] MaxLenW = LenW'(MAX_LEN);

   state_e          state_q;
   logic [31:0]     ptr_q;
   logic [LenW-1:0] len_q;
   logic [2:0]      idx_q;

   logic [31:0]     ptr_inc;
   logic [LenW-1:0] len_inc;
   logic [2:0]      idx_dec;
   logic [3:0]      hex_nib;
   logic [7:0]      hex_char;
   logic [7:0]      str_byte;

   assign ptr_inc  = ptr_q + 32'd1;
   assign len_inc  = len_q + 1'b1;
   assign idx_dec  = idx_q - 3'd1;
   assign str_byte = mem_rdata[{ptr_q[1:0], 3'b000} +: 8];

   // char_out is registered, so the mapper looks one digit ahead of the one on display.
   assign hex_nib = (state_q == StIdle) ? a0[31:28] : ptr_q[{idx_dec, 2'b00} +: 4];

   hex_nibble_to_ascii u_hex (
      .nibble (hex_nib),
      .ascii  (hex_char)
   );

   // FINISH is the done cycle; releasing stall there lets the pipeline step past SYSCALL once.
   assign stall = ~reset &
                  (((state_q != StIdle) & (state_q != StFinish)) |
                   (syscall & (state_q == StIdle) & ~halt));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         char_out   <= '0;
         char_valid <= 1'b0;
         done       <= 1'b0;
         halt       <= 1'b0;
      end else begin
         done   <= 1'b0;
         mem_rd <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (syscall && !halt) begin
                  ptr_q <= a0;
                  len_q <= '0;
                  if (v0 == SYS_PRINT_STR) begin
                     state_q  <= StStrReq;
                     mem_rd   <= 1'b1;
                     mem_addr <= {a0[31:2], 2'b00};
                  end else if (v0 == SYS_PRINT_HEX) begin
                     state_q    <= StHexEmit;
                     idx_q      <= 3'd7;
                     char_out   <= hex_char;
                     char_valid <= 1'b1;
                  end else if (v0 == SYS_PRINT_CHAR) begin
                     state_q    <= StChrEmit;
                     char_out   <= a0[7:0];
                     char_valid <= 1'b1;
                  end else if (v0 == SYS_EXIT) begin
                     state_q <= StFinish;
                     done    <= 1'b1;
                     halt    <= 1'b1;
                  end else begin
                     state_q <= StFinish;
                     done    <= 1'b1;
                  end
               end
            end

            StStrReq: begin
               state_q <= StStrWait;
            end

            StStrWait: begin
               if (str_byte == 8'h00) begin
                  state_q <= StFinish;
                  done    <= 1'b1;
               end else begin
                  state_q    <= StStrEmit;
                  char_out   <= str_byte;
                  char_valid <= 1'b1;
               end
            end

            StStrEmit: begin
               if (char_ready) begin
                  char_valid <= 1'b0;
                  ptr_q      <= ptr_inc;
                  len_q      <= len_inc;
                  if (len_inc == MaxLenW) begin
                     state_q <= StFinish;
                     done    <= 1'b1;
                  end else begin
                     // Every byte is re-read; no word is cached between characters.
                     state_q  <= StStrReq;
                     mem_rd   <= 1'b1;
                     mem_addr <= {ptr_inc[31:2], 2'b00};
                  end
               end
            end

            StHexEmit: begin
               if (char_ready) begin
                  if (idx_q == 3'd0) begin
                     char_valid <= 1'b0;
                     state_q    <= StFinish;
                     done       <= 1'b1;
                  end else begin
                     idx_q    <= idx_dec;
                     char_out <= hex_char;
                  end
               end
            end

            StChrEmit: begin
               if (char_ready) begin
                  char_valid <= 1'b0;
                  state_q    <= StFinish;
                  done       <= 1'b1;
               end
            end

            StFinish: begin
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_syscall_sequencer.sv
// Directed bench for syscall_sequencer: strings, hex, char, exit/halt, reset and length limit.
module tb_syscall_sequencer;

   logic        clk;
   logic        reset;
   logic        syscall;
   logic [31:0] v0;
   logic [31:0] a0;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        char_ready;
   logic        stall;
   logic        done;
   logic        halt;

   int vecs = 0;
   int errs = 0;

   logic [31:0] mem_w [0:255];
   logic [7:0]  chars [$];
   logic [31:0] addrs [$];

   syscall_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .syscall    (syscall),
      .v0         (v0),
      .a0         (a0),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .stall      (stall),
      .done       (done),
      .halt       (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory model plus accept/read monitors.
   always @(posedge clk) begin
      if (char_valid && char_ready) chars.push_back(char_out);
      if (mem_rd) begin
         addrs.push_back(mem_addr);
         mem_rdata <= mem_w[mem_addr[9:2]];
      end
   end

   task automatic wait_done(input int budget, output int cycles, output logic ok);
      ok = 1'b0;
      cycles = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         cycles++;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      syscall = 1'b0;
      v0 = '0;
      a0 = '0;
      char_ready = 1'b0;
      repeat (2) @(negedge clk);
      vecs++;
      if ({mem_rd, mem_addr, char_out, char_valid, done, halt, stall} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got rd=%b addr=%h ch=%h v=%b d=%b h=%b st=%b want all 0",
                  mem_rd, mem_addr, char_out, char_valid, done, halt, stall);
      end
      reset = 1'b0;
      @(negedge clk);
      vecs++;
      if ({stall, done, char_valid} !== 3'b000) begin
         errs++;
         $display("FAIL idle_after_reset: got stall=%b done=%b valid=%b want 000",
                  stall, done, char_valid);
      end
   endtask

   task automatic test_hello();
      int cyc;
      logic ok;
      logic [7:0] exp_c [3] = '{8'h48, 8'h69, 8'h21};
      mem_w[64] = 32'h0021_6948;
      chars.delete();
      addrs.delete();
      v0 = 32'd4;
      a0 = 32'h100;
      char_ready = 1'b1;
      syscall = 1'b1;
      #1;
      vecs++;
      if (stall !== 1'b1) begin
         errs++;
         $display("FAIL hello_stall_start: got %b want 1", stall);
      end
      wait_done(100, cyc, ok);
      vecs++;
      if (!ok || cyc != 12) begin
         errs++;
         $display("FAIL hello_done_cycle: got ok=%b cyc=%0d want ok=1 cyc=12", ok, cyc);
      end
      vecs++;
      if (stall !== 1'b0) begin
         errs++;
         $display("FAIL hello_stall_done: got %b want 0", stall);
      end
      syscall = 1'b0;
      vecs++;
      if (chars.size() != 3) begin
         errs++;
         $display("FAIL hello_count: got %0d want 3", chars.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (chars[i] !== exp_c[i]) begin
               errs++;
               $display("FAIL hello_char%0d: got %h want %h", i, chars[i], exp_c[i]);
               break;
            end
         end
      end
      vecs++;
      if (addrs.size() != 4 || addrs[0] !== 32'h100 || addrs[1] !== 32'h100 ||
          addrs[2] !== 32'h100 || addrs[3] !== 32'h100) begin
         errs++;
         $display("FAIL hello_addrs: got n=%0d want 4 reads of 00000100", addrs.size());
      end
      @(negedge clk);
   endtask

   task automatic test_unaligned();
      int cyc;
      logic ok;
      logic [7:0]  exp_c [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
      logic [31:0] exp_a [5] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h104};
      mem_w[64] = 32'h6261_5A5A;
      mem_w[65] = 32'h3300_6463;
      chars.delete();
      addrs.delete();
      v0 = 32'd4;
      a0 = 32'h102;
      char_ready = 1'b1;
      syscall = 1'b1;
      wait_done(100, cyc, ok);
      syscall = 1'b0;
      vecs++;
      if (!ok || cyc != 15) begin
         errs++;
         $display("FAIL unaligned_done_cycle: got ok=%b cyc=%0d want ok=1 cyc=15", ok, cyc);
      end
      vecs++;
      if (chars.size() != 4) begin
         errs++;
         $display("FAIL unaligned_count: got %0d want 4", chars.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (chars[i] !== exp_c[i]) begin
               errs++;
               $display("FAIL unaligned_char%0d: got %h want %h", i, chars[i], exp_c[i]);
               break;
            end
         end
      end
      vecs++;
      if (addrs.size() != 5) begin
         errs++;
         $display("FAIL unaligned_nreads: got %0d want 5", addrs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (addrs[i] !== exp_a[i]) begin
               errs++;
               $display("FAIL unaligned_addr%0d: got %h want %h", i, addrs[i], exp_a[i]);
               break;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_hex();
      logic ok;
      logic hold;
      logic [7:0] held;
      logic [7:0] exp_c [8] = '{8'h30, 8'h30, 8'h41, 8'h46, 8'h33, 8'h43, 8'h30, 8'h31};
      chars.delete();
      v0 = 32'd1;
      a0 = 32'h00AF_3C01;
      char_ready = 1'b1;
      syscall = 1'b1;
      ok = 1'b0;
      hold = 1'b0;
      held = '0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (hold) begin
            vecs++;
            if (char_valid !== 1'b1 || char_out !== held) begin
               errs++;
               $display("FAIL hex_hold: got v=%b ch=%h want v=1 ch=%h", char_valid, char_out, held);
            end
         end
         if (done === 1'b1) begin
            ok = 1'b1;
         end else begin
            char_ready = ~char_ready;
            hold = char_valid & ~char_ready;
            held = char_out;
         end
      end
      syscall = 1'b0;
      char_ready = 1'b1;
      vecs++;
      if (!ok) begin
         errs++;
         $display("FAIL hex_done: got no done within 100 cycles want done");
      end
      vecs++;
      if (chars.size() != 8) begin
         errs++;
         $display("FAIL hex_count: got %0d want 8", chars.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (chars[i] !== exp_c[i]) begin
               errs++;
               $display("FAIL hex_char%0d: got %h want %h", i, chars[i], exp_c[i]);
               break;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_char_and_unknown();
      int cyc;
      logic ok;
      chars.delete();
      v0 = 32'd11;
      a0 = 32'h1234_5678;
      char_ready = 1'b1;
      syscall = 1'b1;
      wait_done(20, cyc, ok);
      syscall = 1'b0;
      vecs++;
      if (!ok || cyc != 2 || chars.size() != 1 || chars[0] !== 8'h78) begin
         errs++;
         $display("FAIL char_emit: got ok=%b cyc=%0d n=%0d want ok=1 cyc=2 one char 78",
                  ok, cyc, chars.size());
      end
      @(negedge clk);
      chars.delete();
      addrs.delete();
      v0 = 32'd7;
      syscall = 1'b1;
      wait_done(20, cyc, ok);
      syscall = 1'b0;
      vecs++;
      if (!ok || cyc != 1 || chars.size() != 0 || addrs.size() != 0) begin
         errs++;
         $display("FAIL unknown_code: got ok=%b cyc=%0d chars=%0d reads=%0d want 1/1/0/0",
                  ok, cyc, chars.size(), addrs.size());
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic ok;
      chars.delete();
      v0 = 32'd11;
      a0 = 32'h0000_0041;
      char_ready = 1'b1;
      syscall = 1'b1;
      wait_done(20, cyc, ok);
      vecs++;
      if (!ok || cyc != 2) begin
         errs++;
         $display("FAIL b2b_first: got ok=%b cyc=%0d want ok=1 cyc=2", ok, cyc);
      end
      a0 = 32'h0000_0100;
      wait_done(20, cyc, ok);
      syscall = 1'b0;
      vecs++;
      if (!ok || cyc != 3) begin
         errs++;
         $display("FAIL b2b_second: got ok=%b cyc=%0d want ok=1 cyc=3", ok, cyc);
      end
      vecs++;
      if (chars.size() != 2 || chars[0] !== 8'h41 || chars[1] !== 8'h00) begin
         errs++;
         $display("FAIL b2b_chars: got n=%0d want 41 then 00", chars.size());
      end
      @(negedge clk);
   endtask

   task automatic test_exit_halt();
      int cyc;
      int dones;
      logic ok;
      v0 = 32'd10;
      a0 = '0;
      syscall = 1'b1;
      wait_done(20, cyc, ok);
      syscall = 1'b0;
      vecs++;
      if (!ok || cyc != 1 || halt !== 1'b1) begin
         errs++;
         $display("FAIL exit_done: got ok=%b cyc=%0d halt=%b want 1/1/1", ok, cyc, halt);
      end
      @(negedge clk);
      chars.delete();
      addrs.delete();
      v0 = 32'd4;
      a0 = 32'h100;
      syscall = 1'b1;
      #1;
      vecs++;
      if (stall !== 1'b0) begin
         errs++;
         $display("FAIL halt_stall: got %b want 0", stall);
      end
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      syscall = 1'b0;
      vecs++;
      if (dones != 0 || addrs.size() != 0 || chars.size() != 0 || halt !== 1'b1) begin
         errs++;
         $display("FAIL halt_ignore: got dones=%0d reads=%0d chars=%0d halt=%b want 0/0/0/1",
                  dones, addrs.size(), chars.size(), halt);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vecs++;
      if (halt !== 1'b0) begin
         errs++;
         $display("FAIL reset_clears_halt: got %b want 0", halt);
      end
      mem_w[64] = 32'h0021_6948;
      v0 = 32'd4;
      a0 = 32'h100;
      char_ready = 1'b0;
      syscall = 1'b1;
      repeat (3) @(negedge clk);
      vecs++;
      if (char_valid !== 1'b1 || char_out !== 8'h48 || stall !== 1'b1) begin
         errs++;
         $display("FAIL mid_pre: got v=%b ch=%h st=%b want 1 48 1", char_valid, char_out, stall);
      end
      #2 reset = 1'b1;
      #1;
      vecs++;
      if ({char_valid, stall, mem_rd, char_out} !== '0) begin
         errs++;
         $display("FAIL mid_async: got v=%b st=%b rd=%b ch=%h want all 0",
                  char_valid, stall, mem_rd, char_out);
      end
      syscall = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      char_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_max_len();
      int cyc;
      logic ok;
      for (int w = 128; w < 192; w++) mem_w[w] = 32'h4443_4241;
      chars.delete();
      addrs.delete();
      v0 = 32'd4;
      a0 = 32'h200;
      char_ready = 1'b1;
      syscall = 1'b1;
      wait_done(2000, cyc, ok);
      syscall = 1'b0;
      vecs++;
      if (!ok || cyc != 769) begin
         errs++;
         $display("FAIL maxlen_done: got ok=%b cyc=%0d want ok=1 cyc=769", ok, cyc);
      end
      vecs++;
      if (chars.size() != 256 || chars[0] !== 8'h41 || chars[255] !== 8'h44) begin
         errs++;
         $display("FAIL maxlen_chars: got n=%0d want 256 from A to D", chars.size());
      end
      vecs++;
      if (addrs.size() != 256 || addrs[255] !== 32'h2FC) begin
         errs++;
         $display("FAIL maxlen_reads: got n=%0d want 256 ending at 000002fc", addrs.size());
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_w[i] = '0;
      mem_rdata = '0;
      test_reset();
      test_hello();
      test_unaligned();
      test_hex();
      test_char_and_unknown();
      test_back_to_back();
      test_exit_halt();
      test_reset_mid();
      test_max_len();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
